// File: rtl/shift_pkg.sv
// Shared types and width helper for the rotate request stage and the rotator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        HOLD
    } shift_state_t;

    // Width of a rotate amount able to hold 0..N (one spare bit for the remainder).
    function automatic int amt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mod_reduce_step.sv
// One restoring-remainder step: shift in the next amount bit, subtract N if it overflows.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mod_reduce_step
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int MW = amt_w(N)
) (
    input  logic [MW-1:0] r,
    input  logic          a_bit,
    output logic [MW-1:0] r_next
);

    localparam logic [MW:0] N_EXT = (MW + 1)'(N);

    logic [MW:0] shifted;

    assign shifted = {r, a_bit};

    // Remainder stays below N because the shifted value is always below 2N.
    always_comb begin
        r_next = shifted[MW-1:0];
        if (shifted >= N_EXT) begin
            r_next = MW'(shifted - N_EXT);
        end
    end

endmodule

// File: rtl/shift_amount_reducer.sv
// Rotate request stage: captures data/direction and reduces the shift count modulo N.
// Latency: 1 cycle when amount < N, AW+1 cycles otherwise (one amount bit per cycle).
// Backpressure: holds outputs while out_ready_i is low; req_ready_o follows out_ready_i in HOLD.
module shift_amount_reducer
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [N-1:0]        req_data_i,
    input  logic [AW-1:0]       req_amount_i,
    input  logic                req_direction_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N-1:0]        out_data_o,
    output logic [amt_w(N)-1:0] out_amount_o,
    output logic                out_direction_o
);

    localparam int MW = amt_w(N);
    localparam int IW = (AW > 1) ? $clog2(AW) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(AW - 1);
    localparam logic [AW-1:0] N_AW = AW'(N);

    shift_state_t  state;
    logic [AW-1:0] amt_q;
    logic [IW-1:0] idx_q;
    logic [MW-1:0] rem_q;
    logic [MW-1:0] rem_next;
    logic          accept;
    logic          short_amt;

    assign req_ready_o  = (state == IDLE) | ((state == HOLD) & out_ready_i);
    assign accept       = req_valid_i & req_ready_o;
    assign short_amt    = (req_amount_i < N_AW);
    assign out_amount_o = rem_q;

    mod_reduce_step #(
        .N  (N),
        .MW (MW)
    ) u_step (
        .r      (rem_q),
        .a_bit  (amt_q[idx_q]),
        .r_next (rem_next)
    );

    // Control and capture: accept from IDLE or HOLD hand-off, walk amount bits MSB first in REDUCE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            out_valid_o     <= 1'b0;
            out_data_o      <= '0;
            out_direction_o <= 1'b0;
            amt_q           <= '0;
            idx_q           <= '0;
            rem_q           <= '0;
        end else if (accept) begin
            out_data_o      <= req_data_i;
            out_direction_o <= req_direction_i;
            amt_q           <= req_amount_i;
            if (short_amt) begin
                rem_q       <= req_amount_i[MW-1:0];
                state       <= HOLD;
                out_valid_o <= 1'b1;
            end else begin
                rem_q       <= '0;
                idx_q       <= IDX_TOP;
                state       <= REDUCE;
                out_valid_o <= 1'b0;
            end
        end else begin
            case (state)
                REDUCE: begin
                    rem_q <= rem_next;
                    if (idx_q == '0) begin
                        state       <= HOLD;
                        out_valid_o <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_amount_reducer.sv
// Bench for the rotate request stage: directed cases, backpressure, async reset, random soak.
// Latency: checks 1-cycle short path and AW+1-cycle long path.
// Backpressure: drives random out_ready and checks outputs stay put while stalled.
module tb_shift_amount_reducer;

    localparam int AW = 8;

    logic clk;
    logic rst_n;

    // N = 8 instance
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic [7:0] req_amount;
    logic       req_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_amount;
    logic       out_dir;

    // N = 6 instance
    logic       req_valid6;
    logic       req_ready6;
    logic [5:0] req_data6;
    logic [7:0] req_amount6;
    logic       req_dir6;
    logic       out_valid6;
    logic       out_ready6;
    logic [5:0] out_data6;
    logic [2:0] out_amount6;
    logic       out_dir6;

    int checks   = 0;
    int failures = 0;

    // Reference model: a single pending slot, a countdown for the long path, ordered expectations.
    bit          m_hold;
    int          m_left;
    logic [7:0]  q_data[$];
    int          q_amt[$];
    logic        q_dir[$];

    shift_amount_reducer #(.N(8), .AW(AW)) u_dut8 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_data_i      (req_data),
        .req_amount_i    (req_amount),
        .req_direction_i (req_dir),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_amount_o    (out_amount),
        .out_direction_o (out_dir)
    );

    shift_amount_reducer #(.N(6), .AW(AW)) u_dut6 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid6),
        .req_ready_o     (req_ready6),
        .req_data_i      (req_data6),
        .req_amount_i    (req_amount6),
        .req_direction_i (req_dir6),
        .out_valid_o     (out_valid6),
        .out_ready_i     (out_ready6),
        .out_data_o      (out_data6),
        .out_amount_o    (out_amount6),
        .out_direction_o (out_dir6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        m_left = 0;
        q_data.delete();
        q_amt.delete();
        q_dir.delete();
    endtask

    // One clock cycle on the N=8 instance: drive, check against the model, advance the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] a,
                         input logic dr, input logic ordy);
        bit exp_ready;
        bit acc;
        bit take;
        @(negedge clk);
        req_valid  = v;
        req_data   = d;
        req_amount = a;
        req_dir    = dr;
        out_ready  = ordy;
        #1;
        exp_ready = (m_left == 0) && (!m_hold || ordy);
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (m_hold) begin
            if (q_data.size() == 0) begin
                chk("queue_nonempty", 32'd0, 32'd1);
            end else begin
                chk("out_data", 32'(out_data), 32'(q_data[0]));
                chk("out_amount", 32'(out_amount), 32'(q_amt[0]));
                chk("out_dir", 32'(out_dir), 32'(q_dir[0]));
            end
        end
        take = m_hold && ordy;
        acc  = v && exp_ready;
        if (take && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_amt.pop_front());
            void'(q_dir.pop_front());
        end
        if (acc) begin
            q_data.push_back(d);
            q_amt.push_back(int'(a) % 8);
            q_dir.push_back(dr);
            if (int'(a) < 8) begin
                m_hold = 1;
            end else begin
                m_hold = 0;
                m_left = AW;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_hold = 1;
        end else if (take) begin
            m_hold = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    // Single request on the N=6 instance; measures cycles until out_valid appears.
    task automatic run6(input logic [7:0] a, input int exp_amt, input int exp_lat);
        int lat;
        @(negedge clk);
        req_valid6  = 1'b1;
        req_amount6 = a;
        req_data6   = 6'(a);
        req_dir6    = a[0];
        out_ready6  = 1'b1;
        @(negedge clk);
        req_valid6 = 1'b0;
        lat = 1;
        while (!out_valid6 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("n6_latency", 32'(lat), 32'(exp_lat));
        chk("n6_amount", 32'(out_amount6), 32'(exp_amt));
        chk("n6_data", 32'(out_data6), 32'(6'(a)));
        chk("n6_dir", 32'(out_dir6), 32'(a[0]));
    endtask

    initial begin
        req_valid = 0; req_data = 0; req_amount = 0; req_dir = 0; out_ready = 0;
        req_valid6 = 0; req_data6 = 0; req_amount6 = 0; req_dir6 = 0; out_ready6 = 1;
        model_reset();
        rst_n = 1'b0;
        #23;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_amount", 32'(out_amount), 32'd0);
        chk("rst_out_dir", 32'(out_dir), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Short path, back-to-back with out_ready held high.
        cycle(1'b1, 8'hA5, 8'd3, 1'b1, 1'b1);
        cycle(1'b1, 8'h11, 8'd1, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 8'd2, 1'b1, 1'b1);
        cycle(1'b1, 8'h33, 8'd7, 1'b0, 1'b1);
        idle(2);

        // Long path: exact N, all-ones, zero; requests offered during REDUCE must be ignored.
        cycle(1'b1, 8'h5A, 8'd8, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'hEE, 8'd1, 1'b1, 1'b1);
        idle(2);
        cycle(1'b1, 8'hC3, 8'd255, 1'b1, 1'b1);
        idle(10);
        cycle(1'b1, 8'h0F, 8'd0, 1'b1, 1'b1);
        cycle(1'b1, 8'hF0, 8'd64, 1'b0, 1'b1);
        idle(10);

        // Backpressure: stall 5 cycles in HOLD, then release together with a new request.
        cycle(1'b1, 8'h3C, 8'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h99, 8'd2, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 8'd4, 1'b1, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of REDUCE.
        cycle(1'b1, 8'hB7, 8'd200, 1'b1, 1'b1);
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_out_amount", 32'(out_amount), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h4D, 8'd100, 1'b0, 1'b1);
        idle(11);

        // Non-power-of-two modulus.
        run6(8'd200, 2, 9);
        run6(8'd6, 0, 9);
        run6(8'd5, 5, 1);
        run6(8'd255, 3, 9);

        // Random soak: mix of short and long amounts, random downstream readiness.
        for (int i = 0; i < 20000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), a, 1'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end
        idle(12);
        chk("drain_empty", 32'(q_data.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
